// File: rtl/hd_bitop_if.sv
// Handshake bundle for hd_bitop_pipe: operand/opcode in, result/zero/count out.
interface hd_bitop_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_x;
  logic [1:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic             out_zero;
  logic [CNT_W-1:0] done_cnt;
  logic             busy;

  modport master (
    output in_valid, in_x, in_op, out_ready,
    input  in_ready, out_valid, out_y, out_zero, done_cnt, busy
  );

  modport slave (
    input  in_valid, in_x, in_op, out_ready,
    output in_ready, out_valid, out_y, out_zero, done_cnt, busy
  );
endinterface

// File: rtl/hd_bitop_pipe.sv
// Two-stage valid/ready pipeline around the rightmost-bit operators
// (turn off, isolate, isolate-lowest-zero, mask-through-lowest-one).
module hd_bitop_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  hd_bitop_if.slave    bus
);

  logic             s1_v_q, s1_v_d;
  logic [WIDTH-1:0] x1_q, x1_d;
  logic [1:0]       op1_q, op1_d;
  logic             s2_v_q, s2_v_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             zero_q, zero_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             s2_free, s1_adv, s1_free, in_xfer, out_xfer;
  logic [WIDTH-1:0] x_m1, x_p1, x_neg, f_res;

  // Ready chain is purely combinational so a full pipe can still move every cycle.
  always_comb begin
    s2_free  = !s2_v_q || bus.out_ready;
    s1_adv   = s1_v_q && s2_free;
    s1_free  = !s1_v_q || s1_adv;
    in_xfer  = bus.in_valid && s1_free;
    out_xfer = s2_v_q && bus.out_ready;
  end

  always_comb begin
    x_m1  = x1_q - WIDTH'(1);
    x_p1  = x1_q + WIDTH'(1);
    x_neg = ~x1_q + WIDTH'(1);
    case (op1_q)
      2'd0:    f_res = x1_q & x_m1;
      2'd1:    f_res = x1_q & x_neg;
      2'd2:    f_res = ~x1_q & x_p1;
      default: f_res = x1_q ^ x_m1;
    endcase
  end

  always_comb begin
    s1_v_d = s1_v_q;
    x1_d   = x1_q;
    op1_d  = op1_q;
    if (in_xfer) begin
      s1_v_d = 1'b1;
      x1_d   = bus.in_x;
      op1_d  = bus.in_op;
    end else if (s1_adv) begin
      s1_v_d = 1'b0;
    end

    s2_v_d = s2_v_q;
    y_d    = y_q;
    zero_d = zero_q;
    if (s1_adv) begin
      s2_v_d = 1'b1;
      y_d    = f_res;
      zero_d = (f_res == '0);
    end else if (out_xfer) begin
      s2_v_d = 1'b0;
    end

    cnt_d = cnt_q + CNT_W'(out_xfer);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q <= 1'b0;
      x1_q   <= '0;
      op1_q  <= '0;
      s2_v_q <= 1'b0;
      y_q    <= '0;
      zero_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      s1_v_q <= s1_v_d;
      x1_q   <= x1_d;
      op1_q  <= op1_d;
      s2_v_q <= s2_v_d;
      y_q    <= y_d;
      zero_q <= zero_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.in_ready  = s1_free;
  assign bus.out_valid = s2_v_q;
  assign bus.out_y     = y_q;
  assign bus.out_zero  = zero_q;
  assign bus.done_cnt  = cnt_q;
  assign bus.busy      = s1_v_q || s2_v_q;

endmodule

// File: tb/tb_hd_bitop_pipe.sv
// Self-checking bench for hd_bitop_pipe: table vectors, backpressure, random
// stress against a loop-based reference, async reset, and counter wrap.
module tb_hd_bitop_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hd_bitop_if #(.WIDTH(8), .CNT_W(16)) bus ();
  hd_bitop_if #(.WIDTH(8), .CNT_W(4))  bus_w ();

  hd_bitop_pipe #(.WIDTH(8), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  hd_bitop_pipe #(.WIDTH(8), .CNT_W(4)) dut_w (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_w)
  );

  typedef struct {
    logic [7:0] x;
    logic [1:0] op;
    logic [7:0] y;
    logic       z;
  } vec_t;

  typedef struct {
    logic [7:0] y;
    logic       z;
    int         cyc;
    bit         lat;
  } sb_t;

  vec_t       vecs[15];
  sb_t        sbq[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  logic [7:0] cur_y;
  logic       cur_z;
  bit         lat_mode;
  bit         rnd_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_f(input logic [1:0] op, input logic [7:0] x);
    int lo1 = -1;
    int lo0 = -1;
    logic [7:0] r;
    for (int i = 7; i >= 0; i--) begin
      if (x[i]) lo1 = i;
      else      lo0 = i;
    end
    r = 8'h00;
    case (op)
      2'd0: begin
        r = x;
        if (lo1 >= 0) r[lo1] = 1'b0;
      end
      2'd1: if (lo1 >= 0) r[lo1] = 1'b1;
      2'd2: if (lo0 >= 0) r[lo0] = 1'b1;
      default: begin
        if (lo1 < 0) r = 8'hFF;
        else for (int i = 0; i <= lo1; i++) r[i] = 1'b1;
      end
    endcase
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: pop/compare on output handshake, push on input handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready) begin
        if (sbq.size() == 0) begin
          chk("unexpected_output", {24'h0, bus.out_y}, 32'hDEAD);
        end else begin
          sb_t e;
          e = sbq.pop_front();
          chk("out_y", {24'h0, bus.out_y}, {24'h0, e.y});
          chk("out_zero", {31'h0, bus.out_zero}, {31'h0, e.z});
          if (e.lat) chk("latency", cyc - e.cyc, 2);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        sb_t n;
        n.y = cur_y; n.z = cur_z; n.cyc = cyc; n.lat = lat_mode;
        sbq.push_back(n);
      end
    end
  end

  task automatic send(input logic [7:0] x, input logic [1:0] op,
                      input logic [7:0] ey, input logic ez);
    int n = 0;
    cur_y = ey;
    cur_z = ez;
    bus.in_x = x;
    bus.in_op = op;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("send_timeout", 1, 0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    while ((sbq.size() != 0 || bus.busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("drain_timeout", 1, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] cnt0;
    logic [7:0]  rx;
    logic [1:0]  rop;

    bus.in_valid = 0; bus.in_x = 0; bus.in_op = 0; bus.out_ready = 1;
    bus_w.in_valid = 0; bus_w.in_x = 0; bus_w.in_op = 0; bus_w.out_ready = 0;
    cur_y = 0; cur_z = 0; lat_mode = 0; rnd_done = 0;

    vecs[0]  = '{8'h58, 2'd0, 8'h50, 1'b0};
    vecs[1]  = '{8'h58, 2'd1, 8'h08, 1'b0};
    vecs[2]  = '{8'h58, 2'd2, 8'h01, 1'b0};
    vecs[3]  = '{8'h58, 2'd3, 8'h0F, 1'b0};
    vecs[4]  = '{8'h00, 2'd0, 8'h00, 1'b1};
    vecs[5]  = '{8'h00, 2'd1, 8'h00, 1'b1};
    vecs[6]  = '{8'h00, 2'd2, 8'h01, 1'b0};
    vecs[7]  = '{8'h00, 2'd3, 8'hFF, 1'b0};
    vecs[8]  = '{8'hFF, 2'd2, 8'h00, 1'b1};
    vecs[9]  = '{8'hFF, 2'd3, 8'h01, 1'b0};
    vecs[10] = '{8'h80, 2'd1, 8'h80, 1'b0};
    vecs[11] = '{8'h80, 2'd3, 8'hFF, 1'b0};
    vecs[12] = '{8'h07, 2'd2, 8'h08, 1'b0};
    vecs[13] = '{8'h5C, 2'd0, 8'h58, 1'b0};
    vecs[14] = '{8'h01, 2'd0, 8'h00, 1'b1};

    // Reset state
    #12;
    chk("rst_out_valid", {31'h0, bus.out_valid}, 0);
    chk("rst_out_y", {24'h0, bus.out_y}, 0);
    chk("rst_out_zero", {31'h0, bus.out_zero}, 0);
    chk("rst_done_cnt", {16'h0, bus.done_cnt}, 0);
    chk("rst_busy", {31'h0, bus.busy}, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 chk("rst_in_ready", {31'h0, bus.in_ready}, 1);

    // Opcode sweep, back-to-back with latency checking
    @(posedge clk); #1;
    lat_mode = 1;
    for (int i = 0; i < 4; i++) send(vecs[i].x, vecs[i].op, vecs[i].y, vecs[i].z);
    drain();
    chk("sweep_done_cnt", {16'h0, bus.done_cnt}, 4);

    @(posedge clk); #1;
    for (int i = 4; i < 15; i++) send(vecs[i].x, vecs[i].op, vecs[i].y, vecs[i].z);
    drain();
    chk("table_done_cnt", {16'h0, bus.done_cnt}, 15);

    // Backpressure: two accepted, third held off
    lat_mode = 0;
    @(posedge clk); #1;
    bus.out_ready = 0;
    cur_y = 8'h50; cur_z = 0;
    bus.in_x = 8'h58; bus.in_op = 2'd0; bus.in_valid = 1;
    @(posedge clk); #1;
    cur_y = 8'h08;
    bus.in_op = 2'd1;
    @(posedge clk); #1;
    cur_y = 8'h01;
    bus.in_x = 8'h00; bus.in_op = 2'd2;
    @(negedge clk);
    chk("bp_in_ready_low", {31'h0, bus.in_ready}, 0);
    chk("bp_out_valid", {31'h0, bus.out_valid}, 1);
    chk("bp_out_y", {24'h0, bus.out_y}, 32'h50);
    repeat (3) @(negedge clk);
    chk("bp_in_ready_hold", {31'h0, bus.in_ready}, 0);
    chk("bp_out_y_stable", {24'h0, bus.out_y}, 32'h50);
    chk("bp_busy", {31'h0, bus.busy}, 1);
    chk("bp_accepted", sbq.size(), 2);
    @(posedge clk); #1;
    bus.out_ready = 1;
    #1 chk("bp_in_ready_release", {31'h0, bus.in_ready}, 1);
    @(posedge clk); #1;
    bus.in_valid = 0;
    drain();
    chk("bp_done_cnt", {16'h0, bus.done_cnt}, 18);

    // Random stress
    cnt0 = bus.done_cnt;
    fork
      begin
        for (int t = 0; t < 1000; t++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          rx = 8'($urandom_range(0, 255));
          rop = 2'($urandom_range(0, 3));
          send(rx, rop, ref_f(rop, rx), ref_f(rop, rx) == 8'h00);
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.out_ready = 1;
    drain();
    chk("rand_done_cnt", {16'h0, bus.done_cnt - cnt0}, 1000);

    // Async reset with two entries in flight
    @(posedge clk); #1;
    bus.out_ready = 0;
    send(8'h11, 2'd0, 8'h10, 1'b0);
    send(8'h22, 2'd1, 8'h02, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'h0, bus.out_valid}, 0);
    chk("mid_rst_busy", {31'h0, bus.busy}, 0);
    chk("mid_rst_done_cnt", {16'h0, bus.done_cnt}, 0);
    chk("mid_rst_out_y", {24'h0, bus.out_y}, 0);
    sbq.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    bus.out_ready = 1;
    #1 chk("mid_rst_in_ready", {31'h0, bus.in_ready}, 1);
    @(posedge clk); #1;
    lat_mode = 1;
    send(8'h58, 2'd1, 8'h08, 1'b0);
    drain();
    chk("post_rst_done_cnt", {16'h0, bus.done_cnt}, 1);

    // Counter wrap on the CNT_W = 4 instance
    @(posedge clk); #1;
    bus_w.in_x = 8'h58; bus_w.in_op = 2'd3;
    bus_w.out_ready = 1; bus_w.in_valid = 1;
    begin
      int n = 0;
      @(negedge clk);
      while (bus_w.done_cnt != 4'd15 && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("wrap_reach_15", {28'h0, bus_w.done_cnt}, 15);
      chk("wrap_out_valid", {31'h0, bus_w.out_valid}, 1);
      @(negedge clk);
      chk("wrap_to_zero", {28'h0, bus_w.done_cnt}, 0);
      chk("wrap_out_y", {24'h0, bus_w.out_y}, 32'h0F);
    end
    bus_w.in_valid = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
